// File: rtl/w29ee011_poll.sv
// rtl/w29ee011_poll.sv - W29EE011 end-of-program detector (toggle-bit / data-polling)
module w29ee011_poll #(
    parameter int OE_LOW_CYCLES  = 3,
    parameter int OE_HIGH_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 240000,
    parameter int CNT_W          = 18
) (
    input  logic       osc,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] expected_data,
    input  logic [7:0] dq,
    output logic       ce_n,
    output logic       oe_n,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] last_data
);

    localparam int PH_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        EVAL    = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [PH_W-1:0]   ph, ph_d;
    logic [CNT_W-1:0]  tcnt, tcnt_d;
    logic [7:0]        prev, prev_d;
    logic              prev_valid, prev_valid_d;
    logic              mode_q, mode_d;
    logic [7:0]        exp_q, exp_d;
    logic [7:0]        last_d;
    logic              ce_n_d, oe_n_d, busy_d, done_d, timeout_d;
    logic              complete;
    logic              expire;

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ph         <= '0;
            tcnt       <= '0;
            prev       <= 8'h00;
            prev_valid <= 1'b0;
            mode_q     <= 1'b0;
            exp_q      <= 8'h00;
            last_data  <= 8'h00;
            ce_n       <= 1'b1;
            oe_n       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_d;
            ph         <= ph_d;
            tcnt       <= tcnt_d;
            prev       <= prev_d;
            prev_valid <= prev_valid_d;
            mode_q     <= mode_d;
            exp_q      <= exp_d;
            last_data  <= last_d;
            ce_n       <= ce_n_d;
            oe_n       <= oe_n_d;
            busy       <= busy_d;
            done       <= done_d;
            timeout    <= timeout_d;
        end
    end

    // Completion is judged on the byte captured during the read that just ended.
    always_comb begin
        if (mode_q)
            complete = (state == EVAL) && (((last_data ^ exp_q) & 8'h80) == 8'h00);
        else
            complete = (state == EVAL) && prev_valid && (((last_data ^ prev) & 8'h40) == 8'h00);
    end

    // tcnt becomes TIMEOUT_CYCLES-1 on this edge.
    assign expire = busy && (tcnt == CNT_W'(TIMEOUT_CYCLES - 2));

    always_comb begin
        state_d      = state;
        ph_d         = ph;
        tcnt_d       = busy ? tcnt + 1'b1 : tcnt;
        prev_d       = prev;
        prev_valid_d = prev_valid;
        mode_d       = mode_q;
        exp_d        = exp_q;
        last_d       = last_data;
        ce_n_d       = ce_n;
        oe_n_d       = oe_n;
        busy_d       = busy;
        done_d       = done;
        timeout_d    = timeout;

        case (state)
            IDLE: begin
                ce_n_d = 1'b1;
                oe_n_d = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    done_d       = 1'b0;
                    timeout_d    = 1'b0;
                    prev_valid_d = 1'b0;
                    mode_d       = mode;
                    exp_d        = expected_data;
                    tcnt_d       = '0;
                    ph_d         = '0;
                    busy_d       = 1'b1;
                    ce_n_d       = 1'b0;
                    oe_n_d       = 1'b0;
                    state_d      = ASSERT;
                end
            end
            ASSERT: begin
                if (ph == PH_W'(OE_LOW_CYCLES - 1)) begin
                    last_d  = dq;
                    oe_n_d  = 1'b1;
                    ph_d    = '0;
                    state_d = RELEASE;
                end else begin
                    ph_d = ph + 1'b1;
                end
            end
            RELEASE: begin
                if (ph == PH_W'(OE_HIGH_CYCLES - 1)) begin
                    ph_d    = '0;
                    state_d = EVAL;
                end else begin
                    ph_d = ph + 1'b1;
                end
            end
            EVAL: begin
                if (complete) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    prev_d       = last_data;
                    prev_valid_d = 1'b1;
                    oe_n_d       = 1'b0;
                    state_d      = ASSERT;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completion on the expiry edge takes priority over the timeout.
        if (expire && !complete) begin
            timeout_d = 1'b1;
            busy_d    = 1'b0;
            ce_n_d    = 1'b1;
            oe_n_d    = 1'b1;
            ph_d      = '0;
            state_d   = IDLE;
        end
    end

endmodule

// File: tb/tb_w29ee011_poll.sv
// tb/tb_w29ee011_poll.sv - randomized self-checking bench for w29ee011_poll
module tb_w29ee011_poll;

    localparam int T = 97;
    localparam int P = 6;

    logic       osc = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] expected_data = 8'h00;
    logic [7:0] dq = 8'h00;
    logic       ce_n, oe_n, busy, done, timeout;
    logic [7:0] last_data;

    int total = 0;
    int bad = 0;
    logic [7:0] seq [0:31];
    int ridx = 0;
    logic oe_prev = 1'b1;

    w29ee011_poll #(
        .OE_LOW_CYCLES(3),
        .OE_HIGH_CYCLES(2),
        .TIMEOUT_CYCLES(T),
        .CNT_W(18)
    ) dut (
        .osc(osc),
        .rst_n(rst_n),
        .start(start),
        .mode(mode),
        .expected_data(expected_data),
        .dq(dq),
        .ce_n(ce_n),
        .oe_n(oe_n),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .last_data(last_data)
    );

    always #5 osc = ~osc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge osc);
        #1;
    endtask

    // Flash model: a new byte appears on each #OE fall, junk while #OE is high.
    task automatic flash_step();
        if (oe_prev && !oe_n) begin
            dq = (ridx < 32) ? seq[ridx] : 8'($urandom);
            ridx++;
        end else if (!oe_prev && oe_n) begin
            dq = 8'($urandom);
        end
        oe_prev = oe_n;
    endtask

    // Reference: read j ends at edge P*j; the poll stops at the first satisfying read
    // or at edge T-1, whichever is earlier (a tie goes to completion).
    task automatic predict(input logic m, input logic [7:0] e,
                           output int end_edge, output logic fin, output logic [7:0] ld);
        int k;
        k = 0;
        for (int j = 1; j <= 30; j++) begin
            if (k == 0) begin
                if (m) begin
                    if (seq[j-1][7] == e[7]) k = j;
                end else if (j >= 2) begin
                    if (seq[j-1][6] == seq[j-2][6]) k = j;
                end
            end
        end
        if (k != 0 && P * k <= T - 1) begin
            fin = 1'b1;
            end_edge = P * k;
            ld = seq[k-1];
        end else begin
            fin = 1'b0;
            end_edge = T - 1;
            ld = 8'h00;
            for (int j = 1; P * j - 3 < T - 1; j++) ld = seq[j-1];
        end
    endtask

    task automatic run_poll(input string nm, input logic m, input logic [7:0] e,
                            input logic chain, input logic stray);
        int ee;
        int stray_at;
        int npass;
        int last_n;
        logic fin;
        logic [7:0] ld;
        logic [2:0] exp_pins;
        predict(m, e, ee, fin, ld);
        stray_at = stray ? int'($urandom_range(ee - 2, 1)) : -10;
        npass = chain ? 2 : 1;
        mode = m;
        expected_data = e;
        start = 1'b1;
        for (int pass = 0; pass < npass; pass++) begin
            last_n = (pass == npass - 1) ? ee + 1 : ee;
            for (int n = 0; n <= last_n; n++) begin
                tick();
                if (n == 0) begin
                    ridx = 0;
                    oe_prev = 1'b1;
                end
                exp_pins = (n < ee) ? {1'b0, ((n % P) < 3) ? 1'b0 : 1'b1, 1'b1} : 3'b110;
                check($sformatf("%s p%0d pins@%0d", nm, pass, n), {ce_n, oe_n, busy}, exp_pins);
                if (n < ee)
                    check($sformatf("%s p%0d flags@%0d", nm, pass, n), {done, timeout}, 2'b00);
                else
                    check($sformatf("%s p%0d flags@%0d", nm, pass, n), {done, timeout},
                          fin ? 2'b10 : 2'b01);
                if (n == ee)
                    check($sformatf("%s p%0d last_data", nm, pass), last_data, ld);
                flash_step();
                if (n == 0) begin
                    start = 1'b0;
                    mode = 1'($urandom);
                    expected_data = 8'($urandom);
                end
                if (pass == 0 && n == stray_at) begin
                    start = 1'b1;
                    mode = 1'($urandom);
                    expected_data = 8'($urandom);
                end
                if (pass == 0 && n == stray_at + 1) start = 1'b0;
                if (chain && pass == 0 && n == ee - 1) begin
                    start = 1'b1;
                    mode = m;
                    expected_data = e;
                end
            end
        end
    endtask

    task automatic gen(input logic m, input logic [7:0] e, input int len);
        for (int j = 0; j < 32; j++) begin
            seq[j] = 8'($urandom);
            if (m) seq[j][7] = (j >= len - 1) ? e[7] : ~e[7];
            else if (j > 0) seq[j][6] = (j < len) ? ~seq[j-1][6] : seq[j-1][6];
        end
    endtask

    initial begin
        logic [7:0] tb6;
        logic       rm;
        logic [7:0] re;
        tick();
        tick();
        check("reset pins", {ce_n, oe_n, busy, done, timeout}, 5'b11000);
        check("reset last_data", last_data, 8'h00);
        rst_n = 1'b1;
        oe_prev = oe_n;
        tick();

        for (int j = 0; j < 32; j++) seq[j] = 8'($urandom);
        tb6 = 8'b00010100;
        for (int j = 0; j < 5; j++) seq[j][6] = tb6[j];
        run_poll("toggle5", 1'b0, 8'h00, 1'b0, 1'b0);
        check("toggle5 dq6", {31'd0, last_data[6]}, 32'd0);

        for (int j = 0; j < 32; j++) seq[j] = 8'h5A;
        seq[0] = 8'hA5;
        run_poll("data_imm", 1'b1, 8'hA5, 1'b1, 1'b0);

        for (int j = 0; j < 32; j++) seq[j] = 8'h00;
        run_poll("data_to", 1'b1, 8'h80, 1'b0, 1'b0);

        gen(1'b1, 8'h3C, 4);
        run_poll("restart", 1'b1, 8'h3C, 1'b0, 1'b1);

        gen(1'b0, 8'h00, 15);
        run_poll("tie", 1'b0, 8'h00, 1'b0, 1'b0);

        gen(1'b0, 8'h00, 6);
        run_poll("stray", 1'b0, 8'h00, 1'b0, 1'b1);

        gen(1'b1, 8'h80, 20);
        mode = 1'b1;
        expected_data = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async reset pins", {ce_n, oe_n, busy, done, timeout}, 5'b11000);
        check("async reset last_data", last_data, 8'h00);
        tick();
        rst_n = 1'b1;
        oe_prev = oe_n;
        tick();
        check("post reset idle", {ce_n, oe_n, busy}, 3'b110);

        for (int i = 0; i < 12; i++) begin
            rm = 1'($urandom);
            re = 8'($urandom);
            gen(rm, re, int'($urandom_range(18, 1)));
            run_poll($sformatf("rnd%0d", i), rm, re, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
